// File: rtl/wb_sdram_arbiter_if.sv
// Wishbone bundle between NR_OF_PORTS masters, the round-robin arbiter and the
// single SDRAM controller slave port. Per-port fields are packed side by side.
interface wb_sdram_arbiter_if #(
    parameter int NR_OF_PORTS = 4,
    parameter int ADR_W       = 22
);
    logic [32*NR_OF_PORTS-1:0]    m_dat_i;
    logic [ADR_W*NR_OF_PORTS-1:0] m_adr_i;
    logic [4*NR_OF_PORTS-1:0]     m_sel_i;
    logic [3*NR_OF_PORTS-1:0]     m_cti_i;
    logic [2*NR_OF_PORTS-1:0]     m_bte_i;
    logic [NR_OF_PORTS-1:0]       m_we_i;
    logic [NR_OF_PORTS-1:0]       m_cyc_i;
    logic [NR_OF_PORTS-1:0]       m_stb_i;
    logic [31:0]                  m_dat_o;
    logic [NR_OF_PORTS-1:0]       m_ack_o;

    logic [31:0]      s_dat_o;
    logic [ADR_W-1:0] s_adr_o;
    logic [3:0]       s_sel_o;
    logic [2:0]       s_cti_o;
    logic [1:0]       s_bte_o;
    logic             s_we_o;
    logic             s_cyc_o;
    logic             s_stb_o;
    logic [31:0]      s_dat_i;
    logic             s_ack_i;

    // Arbiter side
    modport slave (
        input  m_dat_i, m_adr_i, m_sel_i, m_cti_i, m_bte_i, m_we_i, m_cyc_i, m_stb_i,
        input  s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o,
        output s_dat_o, s_adr_o, s_sel_o, s_cti_o, s_bte_o, s_we_o, s_cyc_o, s_stb_o
    );

    // Masters plus SDRAM controller side
    modport master (
        output m_dat_i, m_adr_i, m_sel_i, m_cti_i, m_bte_i, m_we_i, m_cyc_i, m_stb_i,
        output s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o,
        input  s_dat_o, s_adr_o, s_sel_o, s_cti_o, s_bte_o, s_we_o, s_cyc_o, s_stb_o
    );
endinterface

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone B3 arbiter in front of the SDRAM controller; the grant is
// held for a whole classic or burst cycle and re-arbitrated only between cycles.

// One port's contribution to the AND-OR slave mux: zero unless selected.
module wb_sdram_arbiter_port #(
    parameter int ADR_W = 22
) (
    input  logic             sel,
    input  logic [31:0]      dat_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [3:0]       bsel_i,
    input  logic [2:0]       cti_i,
    input  logic [1:0]       bte_i,
    input  logic             we_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    output logic [31:0]      dat_o,
    output logic [ADR_W-1:0] adr_o,
    output logic [3:0]       bsel_o,
    output logic [2:0]       cti_o,
    output logic [1:0]       bte_o,
    output logic             we_o,
    output logic             cyc_o,
    output logic             stb_o
);
    assign dat_o  = sel ? dat_i  : '0;
    assign adr_o  = sel ? adr_i  : '0;
    assign bsel_o = sel ? bsel_i : '0;
    assign cti_o  = sel ? cti_i  : '0;
    assign bte_o  = sel ? bte_i  : '0;
    assign we_o   = sel & we_i;
    assign cyc_o  = sel & cyc_i;
    assign stb_o  = sel & stb_i;
endmodule

module wb_sdram_arbiter #(
    parameter int NR_OF_PORTS = 4,
    parameter int ADR_W       = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_sdram_arbiter_if.slave      bus,
    output logic [NR_OF_PORTS-1:0] gnt_o
);
    localparam int PW = (NR_OF_PORTS > 1) ? $clog2(NR_OF_PORTS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [NR_OF_PORTS-1:0] gnt_q, gnt_d;
    logic [PW-1:0]          ptr_q, ptr_d;

    logic [NR_OF_PORTS-1:0]            req;
    logic [NR_OF_PORTS-1:0][2:0]       m_cti;
    logic [PW-1:0]                     win;
    logic                              win_vld;
    logic [2:0]                        cti_g;
    logic                              cyc_g;
    logic                              busy;
    logic                              release_cyc;

    assign busy  = (state_q == BUSY);
    assign req   = bus.m_cyc_i & bus.m_stb_i;
    assign m_cti = bus.m_cti_i;

    // The pointer holds the granted port while BUSY and the last served port while IDLE.
    assign cti_g = m_cti[ptr_q];
    assign cyc_g = bus.m_cyc_i[ptr_q];
    assign release_cyc = !cyc_g ||
                         (bus.s_ack_i && (cti_g == 3'b000 || cti_g == 3'b111));

    // First requester above the last served port, wrapping around.
    always_comb begin
        win     = ptr_q;
        win_vld = 1'b0;
        for (int i = 1; i <= NR_OF_PORTS; i++) begin
            int unsigned idx;
            idx = (int'(ptr_q) + i) % NR_OF_PORTS;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BUSY;
                    gnt_d   = NR_OF_PORTS'(1) << win;
                    ptr_d   = win;
                end
            end
            BUSY: begin
                if (release_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PW'(NR_OF_PORTS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_o = gnt_q;

    assign bus.m_ack_o = gnt_q & {NR_OF_PORTS{bus.s_ack_i & busy}};
    assign bus.m_dat_o = bus.s_dat_i;

    logic [NR_OF_PORTS-1:0][31:0]      sl_dat;
    logic [NR_OF_PORTS-1:0][ADR_W-1:0] sl_adr;
    logic [NR_OF_PORTS-1:0][3:0]       sl_sel;
    logic [NR_OF_PORTS-1:0][2:0]       sl_cti;
    logic [NR_OF_PORTS-1:0][1:0]       sl_bte;
    logic [NR_OF_PORTS-1:0]            sl_we, sl_cyc, sl_stb;

    for (genvar k = 0; k < NR_OF_PORTS; k++) begin : g_port
        wb_sdram_arbiter_port #(.ADR_W(ADR_W)) u_port (
            .sel    (gnt_q[k] & busy),
            .dat_i  (bus.m_dat_i[32*k +: 32]),
            .adr_i  (bus.m_adr_i[ADR_W*k +: ADR_W]),
            .bsel_i (bus.m_sel_i[4*k +: 4]),
            .cti_i  (bus.m_cti_i[3*k +: 3]),
            .bte_i  (bus.m_bte_i[2*k +: 2]),
            .we_i   (bus.m_we_i[k]),
            .cyc_i  (bus.m_cyc_i[k]),
            .stb_i  (bus.m_stb_i[k]),
            .dat_o  (sl_dat[k]),
            .adr_o  (sl_adr[k]),
            .bsel_o (sl_sel[k]),
            .cti_o  (sl_cti[k]),
            .bte_o  (sl_bte[k]),
            .we_o   (sl_we[k]),
            .cyc_o  (sl_cyc[k]),
            .stb_o  (sl_stb[k])
        );
    end

    // Grant is one-hot, so OR-ing the masked slices is the mux.
    always_comb begin
        bus.s_dat_o = '0;
        bus.s_adr_o = '0;
        bus.s_sel_o = '0;
        bus.s_cti_o = '0;
        bus.s_bte_o = '0;
        for (int k = 0; k < NR_OF_PORTS; k++) begin
            bus.s_dat_o = bus.s_dat_o | sl_dat[k];
            bus.s_adr_o = bus.s_adr_o | sl_adr[k];
            bus.s_sel_o = bus.s_sel_o | sl_sel[k];
            bus.s_cti_o = bus.s_cti_o | sl_cti[k];
            bus.s_bte_o = bus.s_bte_o | sl_bte[k];
        end
    end

    assign bus.s_we_o  = |sl_we;
    assign bus.s_cyc_o = |sl_cyc;
    assign bus.s_stb_o = |sl_stb;
endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter: reset, single master, contention order,
// wrap burst, write stall, abort and reset mid-burst.
module tb_wb_sdram_arbiter;
    localparam int N  = 4;
    localparam int AW = 22;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] gnt;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    wb_sdram_arbiter_if #(.NR_OF_PORTS(N), .ADR_W(AW)) bus ();

    wb_sdram_arbiter #(.NR_OF_PORTS(N), .ADR_W(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .gnt_o (gnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [2:0] cti, input logic [1:0] bte,
                         input logic [AW-1:0] adr, input logic [31:0] dat);
        bus.m_cyc_i[k]          = cyc;
        bus.m_stb_i[k]          = stb;
        bus.m_we_i[k]           = we;
        bus.m_cti_i[k*3 +: 3]   = cti;
        bus.m_bte_i[k*2 +: 2]   = bte;
        bus.m_adr_i[k*AW +: AW] = adr;
        bus.m_dat_i[k*32 +: 32] = dat;
        bus.m_sel_i[k*4 +: 4]   = 4'hf;
    endtask

    task automatic drop(input int k);
        drive(k, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, '0, '0);
    endtask

    task automatic test_reset;
        bus.m_dat_i = '0; bus.m_adr_i = '0; bus.m_sel_i = '0; bus.m_cti_i = '0;
        bus.m_bte_i = '0; bus.m_we_i = '0; bus.m_cyc_i = '0; bus.m_stb_i = '0;
        bus.s_dat_i = 32'hdeadbeef;
        bus.s_ack_i = 1'b1;
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 22'h0000aa, '0);
        tick; tick;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected 0", bus.s_cyc_o); end
        checks++; if (bus.s_adr_o !== 22'h0) begin errors++; $display("FAIL reset_s_adr: got %h expected 0", bus.s_adr_o); end
        checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL reset_m_ack: got %b expected 0000", bus.m_ack_o); end
        checks++; if (bus.m_dat_o !== 32'hdeadbeef) begin errors++; $display("FAIL reset_m_dat: got %h expected deadbeef", bus.m_dat_o); end
        drop(0);
        bus.s_ack_i = 1'b0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        drive(2, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 22'h001234, '0);
        #1;
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_pre_cyc: got %b expected 0", bus.s_cyc_o); end
        tick;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
        checks++; if (bus.s_adr_o !== 22'h001234) begin errors++; $display("FAIL single_adr: got %h expected 001234", bus.s_adr_o); end
        checks++; if ({bus.s_cyc_o, bus.s_stb_o} !== 2'b11) begin errors++; $display("FAIL single_cyc_stb: got %b expected 11", {bus.s_cyc_o, bus.s_stb_o}); end
        checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL single_no_ack: got %b expected 0000", bus.m_ack_o); end
        bus.s_ack_i = 1'b1;
        #1;
        checks++; if (bus.m_ack_o !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", bus.m_ack_o); end
        tick;
        bus.s_ack_i = 1'b0;
        drop(2);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_idle: got %b expected 0000", gnt); end
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_idle_cyc: got %b expected 0", bus.s_cyc_o); end
    endtask

    task automatic test_contention;
        int order [4] = '{0, 1, 3, 0};
        logic [N-1:0] exp;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 22'h000100, '0);
        drive(1, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 22'h000200, '0);
        drive(3, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 22'h000300, '0);
        tick;
        for (int i = 0; i < 4; i++) begin
            exp = N'(1) << order[i];
            checks++; if (gnt !== exp) begin errors++; $display("FAIL contention_gnt%0d: got %b expected %b", i, gnt, exp); end
            bus.s_ack_i = 1'b1;
            #1;
            checks++; if (bus.m_ack_o !== exp) begin errors++; $display("FAIL contention_ack%0d: got %b expected %b", i, bus.m_ack_o, exp); end
            tick;
            bus.s_ack_i = 1'b0;
            // port 0 keeps requesting after its first service
            if (i != 0) drop(order[i]);
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL contention_gap%0d: got %b expected 0000", i, gnt); end
            tick;
        end
    endtask

    task automatic test_burst;
        drive(1, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 22'h000040, '0);
        drive(0, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 22'h000500, '0);
        tick;
        for (int b = 0; b < 4; b++) begin
            drive(1, 1'b1, 1'b1, 1'b0, (b == 3) ? 3'b111 : 3'b010, 2'b01, 22'h000040 + 22'(b), '0);
            bus.s_ack_i = 1'b1;
            #1;
            checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL burst_gnt%0d: got %b expected 0010", b, gnt); end
            checks++; if (bus.m_ack_o !== 4'b0010) begin errors++; $display("FAIL burst_ack%0d: got %b expected 0010", b, bus.m_ack_o); end
            checks++; if (bus.s_bte_o !== 2'b01) begin errors++; $display("FAIL burst_bte%0d: got %b expected 01", b, bus.s_bte_o); end
            tick;
        end
        bus.s_ack_i = 1'b0;
        drop(1);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL burst_gap: got %b expected 0000", gnt); end
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL burst_next: got %b expected 0001", gnt); end
        bus.s_ack_i = 1'b1;
        tick;
        bus.s_ack_i = 1'b0;
        drop(0);
    endtask

    task automatic test_stall;
        drive(2, 1'b1, 1'b1, 1'b1, 3'b010, 2'b01, 22'h000080, 32'h11223344);
        tick;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL stall_gnt: got %b expected 0100", gnt); end
        checks++; if ({bus.s_we_o, bus.s_dat_o} !== {1'b1, 32'h11223344}) begin errors++; $display("FAIL stall_wdat: got %b/%h expected 1/11223344", bus.s_we_o, bus.s_dat_o); end
        bus.s_ack_i = 1'b1;
        tick;
        bus.s_ack_i = 1'b0;
        drive(2, 1'b1, 1'b0, 1'b1, 3'b010, 2'b01, 22'h000081, 32'h55667788);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({bus.s_cyc_o, bus.s_stb_o} !== 2'b10) begin errors++; $display("FAIL stall_stb%0d: got %b expected 10", c, {bus.s_cyc_o, bus.s_stb_o}); end
            checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL stall_ack%0d: got %b expected 0000", c, bus.m_ack_o); end
            tick;
            checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL stall_hold%0d: got %b expected 0100", c, gnt); end
        end
        for (int b = 1; b < 4; b++) begin
            drive(2, 1'b1, 1'b1, 1'b1, (b == 3) ? 3'b111 : 3'b010, 2'b01, 22'h000080 + 22'(b), 32'h55667788);
            bus.s_ack_i = 1'b1;
            #1;
            checks++; if (bus.m_ack_o !== 4'b0100) begin errors++; $display("FAIL stall_beat%0d: got %b expected 0100", b, bus.m_ack_o); end
            tick;
        end
        bus.s_ack_i = 1'b0;
        drop(2);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL stall_end: got %b expected 0000", gnt); end
        tick;
    endtask

    task automatic test_abort;
        drive(3, 1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 22'h000c00, '0);
        drive(1, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 22'h000d00, '0);
        tick;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL abort_gnt: got %b expected 1000", gnt); end
        bus.s_ack_i = 1'b1;
        tick;
        bus.s_ack_i = 1'b0;
        drop(3);
        #1;
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL abort_s_cyc: got %b expected 0", bus.s_cyc_o); end
        tick;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL abort_idle: got %b expected 0000", gnt); end
        tick;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL abort_next: got %b expected 0010", gnt); end
        checks++; if (bus.s_adr_o !== 22'h000d00) begin errors++; $display("FAIL abort_next_adr: got %h expected 000d00", bus.s_adr_o); end
        bus.s_ack_i = 1'b1;
        tick;
        bus.s_ack_i = 1'b0;
        drop(1);
        tick;
    endtask

    task automatic test_reset_mid_burst;
        drive(3, 1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 22'h000e00, '0);
        drive(0, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 22'h000f00, '0);
        tick;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rstmid_gnt: got %b expected 1000", gnt); end
        bus.s_ack_i = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.s_ack_i = 1'b0;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt_drop: got %b expected 0000", gnt); end
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL rstmid_s_cyc: got %b expected 0", bus.s_cyc_o); end
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_port0_first: got %b expected 0001", gnt); end
        bus.s_ack_i = 1'b1;
        tick;
        bus.s_ack_i = 1'b0;
        drop(0);
        drop(3);
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_burst;
        test_stall;
        test_abort;
        test_reset_mid_burst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
